hdlverifier_trigger_ctrl: RTL and testbench

- Trigger controller that sequences the capture core. Arms on the capture `start` bit and evaluates a user trigger signal against the JTAG-loaded `trigger_setting` word.
- Counts qualifying events and issues the single `trigger` pulse the capture core consumes.
- Sits in the `clk` domain between the DUT probe signals and the capture core's `trigger` input. Also returns status bits for the status register.

---
 rtl/hdlverifier_trigger_pkg.sv | 32 +++
 rtl/hdlverifier_trigger_match.sv | 64 ++++++
 rtl/hdlverifier_trigger_ctrl.sv | 116 +++++++++++
 tb/tb_hdlverifier_trigger_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hdlverifier_trigger_pkg.sv
// Shared constants for the trigger controller: mode and state encodings
// plus the field offsets of the trigger_setting configuration word.
package hdlverifier_trigger_pkg;

  localparam logic [1:0] TRIG_LEVEL  = 2'b00;
  localparam logic [1:0] TRIG_ENTER  = 2'b01;
  localparam logic [1:0] TRIG_EXIT   = 2'b10;
  localparam logic [1:0] TRIG_CHANGE = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FIRED = 2'd3;

  // The compare value always sits at bit 0; the other fields follow it.
  function automatic int maskLsb(input int sigWidth);
    return sigWidth;
  endfunction

  function automatic int modeLsb(input int sigWidth);
    return 2 * sigWidth;
  endfunction

  function automatic int countLsb(input int sigWidth);
    return 2 * sigWidth + 2;
  endfunction

  function automatic int trigWidth(input int sigWidth, input int cntWidth);
    return 2 * sigWidth + 2 + cntWidth;
  endfunction

endpackage

// File: rtl/hdlverifier_trigger_match.sv
// Samples the monitored signal, applies the masked compare and turns the
// selected mode into a single-cycle event strobe for the controller.
module hdlverifier_trigger_match
  import hdlverifier_trigger_pkg::*;
#(
  parameter int SIG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_enable,
  input  logic                 i_load,
  input  logic                 i_eval,
  input  logic [SIG_WIDTH-1:0] i_sig,
  input  logic [SIG_WIDTH-1:0] i_value,
  input  logic [SIG_WIDTH-1:0] i_mask,
  input  logic [1:0]           i_mode,
  output logic                 o_event
);

  logic [SIG_WIDTH-1:0] r_sigD;
  logic [SIG_WIDTH-1:0] r_prevSig;
  logic                 r_prevMatch;
  logic                 w_match;
  logic                 w_changed;
  logic                 w_rawEvent;

  assign w_match   = ((r_sigD ^ i_value) & i_mask) == '0;
  assign w_changed = ((r_sigD ^ r_prevSig) & i_mask) != '0;

  // Register the probe so compare and edge detection see one stable sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sigD <= '0;
    end else if (i_enable) begin
      r_sigD <= i_sig;
    end
  end

  // Previous sample: loaded as a baseline in ARM, then tracked while evaluating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prevSig   <= '0;
      r_prevMatch <= 1'b0;
    end else if (i_enable && (i_load || i_eval)) begin
      r_prevSig   <= r_sigD;
      r_prevMatch <= w_match;
    end
  end

  // Pick the event condition for the latched mode.
  always_comb begin
    w_rawEvent = 1'b0;
    case (i_mode)
      TRIG_LEVEL:  w_rawEvent = w_match;
      TRIG_ENTER:  w_rawEvent = w_match & ~r_prevMatch;
      TRIG_EXIT:   w_rawEvent = ~w_match & r_prevMatch;
      TRIG_CHANGE: w_rawEvent = w_changed;
      default:     w_rawEvent = 1'b0;
    endcase
  end

  assign o_event = i_eval & w_rawEvent;

endmodule

// File: rtl/hdlverifier_trigger_ctrl.sv
// Trigger controller: arms on a rising start, counts qualifying events from
// the match block and emits one trigger pulse per arm.
module hdlverifier_trigger_ctrl
  import hdlverifier_trigger_pkg::*;
#(
  parameter  int SIG_WIDTH  = 8,
  parameter  int CNT_WIDTH  = 4,
  localparam int TRIG_WIDTH = trigWidth(SIG_WIDTH, CNT_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_enable,
  input  logic                  start,
  input  logic [TRIG_WIDTH-1:0] trigger_setting,
  input  logic [SIG_WIDTH-1:0]  trig_signal,
  output logic                  trigger,
  output logic                  armed,
  output logic                  triggered,
  output logic [CNT_WIDTH-1:0]  event_count
);

  localparam int MASK_LSB  = maskLsb(SIG_WIDTH);
  localparam int MODE_LSB  = modeLsb(SIG_WIDTH);
  localparam int COUNT_LSB = countLsb(SIG_WIDTH);

  logic [1:0]           r_state;
  logic                 r_startD;
  logic                 r_trigger;
  logic [CNT_WIDTH-1:0] r_count;
  logic [SIG_WIDTH-1:0] r_cfgValue;
  logic [SIG_WIDTH-1:0] r_cfgMask;
  logic [1:0]           r_cfgMode;
  logic [CNT_WIDTH-1:0] r_cfgTarget;

  logic                 w_startRise;
  logic                 w_event;
  logic [CNT_WIDTH:0]   w_nextCount;
  logic [CNT_WIDTH-1:0] w_target;
  logic [CNT_WIDTH-1:0] w_satCount;
  logic                 w_reached;

  assign w_startRise = start & ~r_startD;
  assign w_nextCount = {1'b0, r_count} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign w_target    = (r_cfgTarget == '0) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : r_cfgTarget;
  assign w_satCount  = w_nextCount[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_nextCount[CNT_WIDTH-1:0];
  assign w_reached   = w_nextCount >= {1'b0, w_target};

  hdlverifier_trigger_match #(
    .SIG_WIDTH (SIG_WIDTH)
  ) u_match (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_enable (clk_enable),
    .i_load   (r_state == ST_ARM),
    .i_eval   (r_state == ST_WAIT),
    .i_sig    (trig_signal),
    .i_value  (r_cfgValue),
    .i_mask   (r_cfgMask),
    .i_mode   (r_cfgMode),
    .o_event  (w_event)
  );

  // Sequencing FSM with start edge detection; start low always wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_startD  <= 1'b0;
      r_trigger <= 1'b0;
    end else if (clk_enable) begin
      r_startD  <= start;
      r_trigger <= 1'b0;
      if (!start) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: if (w_startRise) r_state <= ST_ARM;
          ST_ARM:  r_state <= ST_WAIT;
          ST_WAIT: begin
            if (w_event && w_reached) begin
              r_trigger <= 1'b1;
              r_state   <= ST_FIRED;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  // Freeze the configuration at arm time and count events while waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_cfgValue  <= '0;
      r_cfgMask   <= '0;
      r_cfgMode   <= '0;
      r_cfgTarget <= '0;
    end else if (clk_enable && start) begin
      if (r_state == ST_IDLE && w_startRise) begin
        r_cfgValue  <= trigger_setting[SIG_WIDTH-1:0];
        r_cfgMask   <= trigger_setting[MASK_LSB +: SIG_WIDTH];
        r_cfgMode   <= trigger_setting[MODE_LSB +: 2];
        r_cfgTarget <= trigger_setting[COUNT_LSB +: CNT_WIDTH];
        r_count     <= '0;
      end else if (r_state == ST_WAIT && w_event) begin
        r_count <= w_satCount;
      end
    end
  end

  assign trigger     = r_trigger;
  assign armed       = (r_state == ST_ARM) || (r_state == ST_WAIT);
  assign triggered   = (r_state == ST_FIRED);
  assign event_count = r_count;

endmodule

// File: tb/tb_hdlverifier_trigger_ctrl.sv
// Directed bench for the trigger controller: walks through each mode, the
// start/event priority, config freezing, clock-enable gating and async reset.
module tb_hdlverifier_trigger_ctrl;

  logic        clk;
  logic        reset_n;
  logic        clk_enable;
  logic        start;
  logic [21:0] trigger_setting;
  logic [7:0]  trig_signal;
  logic        trigger;
  logic        armed;
  logic        triggered;
  logic [3:0]  event_count;

  int passCount  = 0;
  int totalCount = 0;
  int pulses;
  int pulseStep;

  hdlverifier_trigger_ctrl #(
    .SIG_WIDTH (8),
    .CNT_WIDTH (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .clk_enable      (clk_enable),
    .start           (start),
    .trigger_setting (trigger_setting),
    .trig_signal     (trig_signal),
    .trigger         (trigger),
    .armed           (armed),
    .triggered       (triggered),
    .event_count     (event_count)
  );

  // Free-running 10 ns capture clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pack {N, mode, mask, value} into the configuration word.
  function automatic logic [21:0] mkSetting(input logic [3:0] n, input logic [1:0] mode,
                                            input logic [7:0] mask, input logic [7:0] value);
    return {n, mode, mask, value};
  endfunction

  // Advance n rising edges and land 1 ns after the last one.
  task automatic stepClock(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the functional inputs between clock edges.
  task automatic applyStimulus(input logic startV, input logic [21:0] settingV, input logic [7:0] sigV);
    start           = startV;
    trigger_setting = settingV;
    trig_signal     = sigV;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Directed test sequence.
  initial begin
    reset_n    = 1'b0;
    clk_enable = 1'b1;
    applyStimulus(1'b0, '0, 8'h00);
    stepClock(2);
    checkOutput("rst_trigger",   32'(trigger),     32'd0);
    checkOutput("rst_armed",     32'(armed),       32'd0);
    checkOutput("rst_triggered", 32'(triggered),   32'd0);
    checkOutput("rst_count",     32'(event_count), 32'd0);
    reset_n = 1'b1;
    stepClock(1);

    $display("[TB] LEVEL mode");
    applyStimulus(1'b1, mkSetting(4'd1, 2'b00, 8'hFF, 8'hA5), 8'h00);
    stepClock(1);
    checkOutput("lvl_armed", 32'(armed), 32'd1);
    stepClock(1);
    trig_signal = 8'hA5;
    stepClock(1);
    checkOutput("lvl_trig_early", 32'(trigger), 32'd0);
    trig_signal = 8'h00;
    stepClock(1);
    checkOutput("lvl_trig",      32'(trigger),     32'd1);
    checkOutput("lvl_triggered", 32'(triggered),   32'd1);
    checkOutput("lvl_count",     32'(event_count), 32'd1);
    stepClock(1);
    checkOutput("lvl_trig_one",  32'(trigger),     32'd0);
    checkOutput("lvl_fired_hold", 32'(triggered),  32'd1);

    $display("[TB] ENTER mode");
    start = 1'b0;
    stepClock(1);
    checkOutput("idle_triggered",  32'(triggered),   32'd0);
    checkOutput("idle_count_hold", 32'(event_count), 32'd1);
    applyStimulus(1'b1, mkSetting(4'd3, 2'b01, 8'h0F, 8'h0F), 8'h00);
    stepClock(2);
    pulses    = 0;
    pulseStep = 0;
    for (int i = 1; i <= 8; i++) begin
      trig_signal = (i % 2 == 1) ? 8'h0F : 8'h00;
      stepClock(1);
      if (trigger === 1'b1) begin
        pulses++;
        pulseStep = i;
      end
    end
    checkOutput("ent_pulses",    32'(pulses),      32'd1);
    checkOutput("ent_step",      32'(pulseStep),   32'd6);
    checkOutput("ent_count",     32'(event_count), 32'd3);
    checkOutput("ent_triggered", 32'(triggered),   32'd1);

    $display("[TB] CHANGE with empty mask");
    start = 1'b0;
    stepClock(1);
    applyStimulus(1'b1, mkSetting(4'd1, 2'b11, 8'h00, 8'h00), 8'h00);
    stepClock(2);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      trig_signal = 8'($urandom);
      stepClock(1);
      if (trigger === 1'b1) pulses++;
    end
    checkOutput("chg_pulses", 32'(pulses),      32'd0);
    checkOutput("chg_count",  32'(event_count), 32'd0);
    checkOutput("chg_armed",  32'(armed),       32'd1);

    $display("[TB] EXIT mode");
    start = 1'b0;
    stepClock(1);
    applyStimulus(1'b1, mkSetting(4'd1, 2'b10, 8'h80, 8'h80), 8'h80);
    stepClock(2);
    stepClock(2);
    checkOutput("exit_no_spurious", 32'(trigger),     32'd0);
    checkOutput("exit_count_zero",  32'(event_count), 32'd0);
    trig_signal = 8'h00;
    stepClock(1);
    checkOutput("exit_trig_early", 32'(trigger), 32'd0);
    stepClock(1);
    checkOutput("exit_trig",  32'(trigger),     32'd1);
    checkOutput("exit_count", 32'(event_count), 32'd1);

    $display("[TB] start drop vs event");
    start = 1'b0;
    stepClock(1);
    applyStimulus(1'b1, mkSetting(4'd1, 2'b00, 8'hFF, 8'hA5), 8'h00);
    stepClock(1);
    checkOutput("rearm_cleared", 32'(event_count), 32'd0);
    stepClock(1);
    trig_signal = 8'hA5;
    stepClock(1);
    start = 1'b0;
    stepClock(1);
    checkOutput("drop_trig",      32'(trigger),     32'd0);
    checkOutput("drop_armed",     32'(armed),       32'd0);
    checkOutput("drop_triggered", 32'(triggered),   32'd0);
    checkOutput("drop_count",     32'(event_count), 32'd0);
    stepClock(1);
    checkOutput("drop_trig_later", 32'(trigger), 32'd0);
    applyStimulus(1'b1, mkSetting(4'd2, 2'b00, 8'hFF, 8'h3C), 8'h3C);
    stepClock(2);
    stepClock(1);
    checkOutput("relatch_count1", 32'(event_count), 32'd1);
    checkOutput("relatch_trig0",  32'(trigger),     32'd0);
    stepClock(1);
    checkOutput("relatch_trig",   32'(trigger),     32'd1);
    checkOutput("relatch_count2", 32'(event_count), 32'd2);

    $display("[TB] frozen config and clock enable");
    start = 1'b0;
    stepClock(1);
    applyStimulus(1'b1, mkSetting(4'd1, 2'b00, 8'hFF, 8'h11), 8'h00);
    stepClock(2);
    applyStimulus(1'b1, mkSetting(4'd1, 2'b00, 8'hFF, 8'h22), 8'h22);
    stepClock(2);
    checkOutput("frozen_trig",  32'(trigger),     32'd0);
    checkOutput("frozen_count", 32'(event_count), 32'd0);
    trig_signal = 8'h11;
    clk_enable  = 1'b0;
    stepClock(3);
    checkOutput("gated_trig",  32'(trigger),     32'd0);
    checkOutput("gated_count", 32'(event_count), 32'd0);
    checkOutput("gated_armed", 32'(armed),       32'd1);
    clk_enable = 1'b1;
    stepClock(1);
    checkOutput("ungated_trig_early", 32'(trigger), 32'd0);
    stepClock(1);
    checkOutput("ungated_trig",  32'(trigger),     32'd1);
    checkOutput("ungated_count", 32'(event_count), 32'd1);

    $display("[TB] async reset during WAIT");
    start = 1'b0;
    stepClock(1);
    applyStimulus(1'b1, mkSetting(4'd15, 2'b00, 8'hFF, 8'h77), 8'h77);
    stepClock(2);
    stepClock(5);
    checkOutput("pre_rst_count", 32'(event_count), 32'd5);
    checkOutput("pre_rst_armed", 32'(armed),       32'd1);
    #2;
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    checkOutput("async_rst_armed", 32'(armed),       32'd0);
    checkOutput("async_rst_count", 32'(event_count), 32'd0);
    checkOutput("async_rst_trig",  32'(trigger),     32'd0);
    stepClock(1);
    reset_n = 1'b1;
    stepClock(2);
    checkOutput("post_rst_idle", 32'(armed), 32'd0);
    start = 1'b1;
    stepClock(1);
    checkOutput("post_rst_arm", 32'(armed), 32'd1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
